// File: rtl/uart_tx_engine.sv
// uart_tx_engine: buffered UART transmitter.
//   A FIFO of FIFO_DEPTH words feeds a framing FSM that sends
//   start + 5..DATA_WIDTH data bits (LSB first) + optional parity + 1/2 stop
//   bits, back to back while data is queued, and can hold the line in break.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   cr_clk_div_i       cycles per bit (0 treated as 1)
//   cr_dlen_i          data bits per frame (clamped to 5..DATA_WIDTH)
//   cr_p_i             parity: 00 none, 10 even, x1 odd
//   cr_s_i             0 = one stop bit, 1 = two
//   cr_brk_i           break request
//   push_valid_i/push_data_i/push_ready_o   FIFO write handshake
//   level_o            FIFO occupancy
//   busy_o             engine not idle
//   done_o             one-cycle pulse after each completed data frame
//   uart_tx_o          serial line, idle high
module uart_tx_engine #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [15:0]                   cr_clk_div_i,
  input  logic [4:0]                    cr_dlen_i,
  input  logic [1:0]                    cr_p_i,
  input  logic                          cr_s_i,
  input  logic                          cr_brk_i,
  input  logic                          push_valid_i,
  input  logic [DATA_WIDTH-1:0]         push_data_i,
  output logic                          push_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          uart_tx_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  // ---------------- FIFO ----------------
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [LW-1:0]         r_level;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = push_valid_i && !w_full;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // ---------------- configuration sanitising ----------------
  logic [15:0] w_div_in;
  logic [4:0]  w_dlen_in;

  always_comb begin
    w_div_in  = (cr_clk_div_i == '0) ? 16'd1 : cr_clk_div_i;
    w_dlen_in = cr_dlen_i;
    if (cr_dlen_i < 5'd5)                    w_dlen_in = 5'd5;
    else if (cr_dlen_i > 5'(DATA_WIDTH))     w_dlen_in = 5'(DATA_WIDTH);
  end

  // ---------------- framing FSM ----------------
  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_baud;
  logic [15:0]           r_div;
  logic [4:0]            r_dlen;
  logic [1:0]            r_par;
  logic                  r_stop2;
  logic [4:0]            r_bitcnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_pacc;
  logic                  r_stop_idx;
  logic                  r_brk_stop;
  logic                  r_done;

  logic                  w_bit_end;
  logic                  w_bit_start;
  logic                  w_enter_brk;
  logic                  w_last_stop;
  logic                  w_cfg_load;
  logic [15:0]           w_baud_load;

  assign w_bit_end   = (r_baud == '0);
  assign w_cfg_load  = w_pop || w_enter_brk;
  assign w_baud_load = w_cfg_load ? (w_div_in - 16'd1) : (r_div - 16'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_bit_start = 1'b0;
    w_enter_brk = 1'b0;
    w_last_stop = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cr_brk_i) begin
          w_state_nxt = S_BREAK;
          w_enter_brk = 1'b1;
          w_bit_start = 1'b1;
        end else if (!w_empty) begin
          w_state_nxt = S_START;
          w_pop       = 1'b1;
          w_bit_start = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_start = 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_bit_start = 1'b1;
          if (r_bitcnt == r_dlen - 5'd1)
            w_state_nxt = (r_par != 2'b00) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_bit_start = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop2 && !r_stop_idx && !r_brk_stop) begin
            w_bit_start = 1'b1;
          end else begin
            w_last_stop = 1'b1;
            if (!cr_brk_i && !w_empty) begin
              w_state_nxt = S_START;
              w_pop       = 1'b1;
              w_bit_start = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      S_BREAK: begin
        // The baud counter saturates at zero here, so release is only
        // honoured once at least one full bit period has elapsed.
        if (w_bit_end && !cr_brk_i) begin
          w_state_nxt = S_STOP;
          w_bit_start = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_baud     <= '0;
      r_div      <= 16'd1;
      r_dlen     <= 5'd5;
      r_par      <= '0;
      r_stop2    <= 1'b0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_pacc     <= 1'b0;
      r_stop_idx <= 1'b0;
      r_brk_stop <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_bit_start)        r_baud <= w_baud_load;
      else if (r_baud != '0)  r_baud <= r_baud - 16'd1;

      if (w_cfg_load) begin
        r_div   <= w_div_in;
        r_dlen  <= w_dlen_in;
        r_par   <= cr_p_i;
        r_stop2 <= cr_s_i;
      end

      if (w_pop) begin
        r_shift    <= r_mem[r_rptr];
        r_bitcnt   <= '0;
        r_pacc     <= 1'b0;
        r_stop_idx <= 1'b0;
        r_brk_stop <= 1'b0;
      end else if (w_enter_brk) begin
        r_stop_idx <= 1'b0;
        r_brk_stop <= 1'b1;
      end else if (r_state == S_DATA && w_bit_end) begin
        r_shift  <= r_shift >> 1;
        r_pacc   <= r_pacc ^ r_shift[0];
        r_bitcnt <= r_bitcnt + 5'd1;
      end else if (r_state == S_STOP && w_bit_end) begin
        r_stop_idx <= 1'b1;
      end

      // The stop bit that closes a break is not a data frame.
      r_done <= w_last_stop && !r_brk_stop;
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    uart_tx_o = 1'b1;
    case (r_state)
      S_START:  uart_tx_o = 1'b0;
      S_DATA:   uart_tx_o = r_shift[0];
      S_PARITY: uart_tx_o = r_par[0] ^ r_pacc;
      S_BREAK:  uart_tx_o = 1'b0;
      default:  uart_tx_o = 1'b1;
    endcase
  end

  assign push_ready_o = !w_full;
  assign level_o      = r_level;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = r_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

  localparam int unsigned DW = 9;
  localparam int unsigned FD = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [15:0]   cr_clk_div_i;
  logic [4:0]    cr_dlen_i;
  logic [1:0]    cr_p_i;
  logic          cr_s_i;
  logic          cr_brk_i;
  logic          push_valid_i;
  logic [DW-1:0] push_data_i;
  logic          push_ready_o;
  logic [2:0]    level_o;
  logic          busy_o;
  logic          done_o;
  logic          uart_tx_o;

  int total = 0;
  int bad   = 0;

  uart_tx_engine #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cr_clk_div_i (cr_clk_div_i),
    .cr_dlen_i    (cr_dlen_i),
    .cr_p_i       (cr_p_i),
    .cr_s_i       (cr_s_i),
    .cr_brk_i     (cr_brk_i),
    .push_valid_i (push_valid_i),
    .push_data_i  (push_data_i),
    .push_ready_o (push_ready_o),
    .level_o      (level_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .uart_tx_o    (uart_tx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg(input logic [15:0] div, input logic [4:0] dlen,
                     input logic [1:0] p, input logic s);
    cr_clk_div_i = div;
    cr_dlen_i    = dlen;
    cr_p_i       = p;
    cr_s_i       = s;
  endtask

  // Called in the first start-bit cycle; returns in the cycle after the
  // last stop-bit cycle, where done_o must be high.
  task automatic expect_frame(input string tag, input logic [15:0] data,
                              input int unsigned dlen, input bit pen,
                              input bit pbit, input int unsigned nstop,
                              input int unsigned div);
    logic [19:0] bits;
    int unsigned nb;
    int unsigned c;
    bits = '0;
    nb = 0;
    bits[nb] = 1'b0; nb++;
    for (int unsigned i = 0; i < dlen; i++) begin
      bits[nb] = data[i]; nb++;
    end
    if (pen) begin
      bits[nb] = pbit; nb++;
    end
    for (int unsigned i = 0; i < nstop; i++) begin
      bits[nb] = 1'b1; nb++;
    end
    c = 0;
    for (int unsigned b = 0; b < nb; b++) begin
      for (int unsigned k = 0; k < div; k++) begin
        chk($sformatf("%s line b%0d c%0d", tag, b, c), uart_tx_o, bits[b]);
        if (c != 0) chk($sformatf("%s nodone c%0d", tag, c), done_o, 1'b0);
        c++;
        tick();
      end
    end
    chk($sformatf("%s done", tag), done_o, 1'b1);
  endtask

  initial begin
    rst_ni       = 1'b0;
    push_valid_i = 1'b0;
    push_data_i  = '0;
    cr_brk_i     = 1'b0;
    cfg(16'd4, 5'd8, 2'b00, 1'b0);
    repeat (3) tick();
    chk("rst line",  uart_tx_o, 1'b1);
    chk("rst ready", push_ready_o, 1'b1);
    chk("rst level", level_o, 3'd0);
    chk("rst busy",  busy_o, 1'b0);
    chk("rst done",  done_o, 1'b0);
    rst_ni = 1'b1;
    repeat (2) tick();

    // 8N1, div 4, 0xA5
    push_valid_i = 1'b1; push_data_i = 9'h0A5;
    tick();
    push_valid_i = 1'b0;
    chk("t1 level1", level_o, 3'd1);
    tick();
    expect_frame("t1", 16'h00A5, 8, 1'b0, 1'b0, 1, 4);
    chk("t1 level0", level_o, 3'd0);
    chk("t1 idle",   busy_o, 1'b0);
    tick();
    chk("t1 done1cyc", done_o, 1'b0);
    tick();

    // 9E2, div 2, 0x1A5 (five ones -> even parity bit 1)
    cfg(16'd2, 5'd9, 2'b10, 1'b1);
    push_valid_i = 1'b1; push_data_i = 9'h1A5;
    tick();
    push_valid_i = 1'b0;
    tick();
    expect_frame("t2", 16'h01A5, 9, 1'b1, 1'b1, 2, 2);
    repeat (2) tick();

    // clamps: div 0 -> 1, dlen 3 -> 5, odd parity, 2 stop; upper bits ignored
    cfg(16'd0, 5'd3, 2'b01, 1'b1);
    push_valid_i = 1'b1; push_data_i = 9'h1EB;
    tick();
    push_valid_i = 1'b0;
    tick();
    expect_frame("t7", 16'h000B, 5, 1'b1, 1'b0, 2, 1);
    repeat (2) tick();

    // three words back to back, div 1, 8N1
    cfg(16'd1, 5'd8, 2'b00, 1'b0);
    push_valid_i = 1'b1; push_data_i = 9'h0C3;
    tick();
    fork
      begin
        push_data_i = 9'h05A; tick();
        push_data_i = 9'h0F0; tick();
        push_valid_i = 1'b0;
      end
      begin
        tick();
        expect_frame("t3a", 16'h00C3, 8, 1'b0, 1'b0, 1, 1);
        expect_frame("t3b", 16'h005A, 8, 1'b0, 1'b0, 1, 1);
        expect_frame("t3c", 16'h00F0, 8, 1'b0, 1'b0, 1, 1);
        chk("t3 idle", busy_o, 1'b0);
      end
    join
    repeat (2) tick();

    // FIFO fill while stalled in break, depth 4, 5 pushes
    cfg(16'd2, 5'd8, 2'b00, 1'b0);
    cr_brk_i = 1'b1;
    tick();
    chk("t4 brk line", uart_tx_o, 1'b0);
    chk("t4 brk busy", busy_o, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) chk("t4 ready full", push_ready_o, 1'b0);
      push_valid_i = 1'b1;
      push_data_i  = DW'(9'h011 * (k + 1));
      tick();
    end
    push_valid_i = 1'b0;
    chk("t4 level4", level_o, 3'd4);
    chk("t4 brk line2", uart_tx_o, 1'b0);
    cr_brk_i = 1'b0;
    tick();
    chk("t4 stop0 line", uart_tx_o, 1'b1);
    chk("t4 stop0 done", done_o, 1'b0);
    tick();
    chk("t4 stop1 line", uart_tx_o, 1'b1);
    chk("t4 stop1 done", done_o, 1'b0);
    tick();
    chk("t4 nodone", done_o, 1'b0);
    expect_frame("t4a", 16'h0011, 8, 1'b0, 1'b0, 1, 2);
    expect_frame("t4b", 16'h0022, 8, 1'b0, 1'b0, 1, 2);
    expect_frame("t4c", 16'h0033, 8, 1'b0, 1'b0, 1, 2);
    expect_frame("t4d", 16'h0044, 8, 1'b0, 1'b0, 1, 2);
    chk("t4 level0", level_o, 3'd0);
    chk("t4 line idle", uart_tx_o, 1'b1);
    chk("t4 idle", busy_o, 1'b0);
    repeat (2) tick();

    // break requested mid-frame with one word pending
    push_valid_i = 1'b1; push_data_i = 9'h03C;
    tick();
    fork
      begin
        push_data_i = 9'h05A; tick();
        push_valid_i = 1'b0;
      end
      begin
        repeat (6) tick();
        cr_brk_i = 1'b1;
      end
      begin
        tick();
        expect_frame("t5a", 16'h003C, 8, 1'b0, 1'b0, 1, 2);
        chk("t5 gap line", uart_tx_o, 1'b1);
        chk("t5 level1", level_o, 3'd1);
        tick();
        chk("t5 brk0 line", uart_tx_o, 1'b0);
        chk("t5 brk0 busy", busy_o, 1'b1);
        cr_brk_i = 1'b0;
        tick();
        chk("t5 brk1 line", uart_tx_o, 1'b0);
        tick();
        chk("t5 stop0 line", uart_tx_o, 1'b1);
        chk("t5 stop0 done", done_o, 1'b0);
        tick();
        chk("t5 stop1 line", uart_tx_o, 1'b1);
        chk("t5 stop1 done", done_o, 1'b0);
        tick();
        chk("t5 nodone", done_o, 1'b0);
        expect_frame("t5b", 16'h005A, 8, 1'b0, 1'b0, 1, 2);
        chk("t5 level0", level_o, 3'd0);
      end
    join
    repeat (2) tick();

    // reset in the middle of DATA with two words queued
    push_valid_i = 1'b1; push_data_i = 9'h000;
    tick();
    fork
      begin
        push_data_i = 9'h00F; tick();
        push_data_i = 9'h0F0; tick();
        push_valid_i = 1'b0;
      end
      begin
        tick();
        repeat (5) tick();
        chk("t6 pre line", uart_tx_o, 1'b0);
        chk("t6 pre busy", busy_o, 1'b1);
        chk("t6 pre level", level_o, 3'd2);
        rst_ni = 1'b0;
        #1;
        chk("t6 rst line",  uart_tx_o, 1'b1);
        chk("t6 rst level", level_o, 3'd0);
        chk("t6 rst busy",  busy_o, 1'b0);
        chk("t6 rst ready", push_ready_o, 1'b1);
        chk("t6 rst done",  done_o, 1'b0);
      end
    join
    repeat (2) tick();
    rst_ni = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk($sformatf("t6 quiet line c%0d", k), uart_tx_o, 1'b1);
      chk($sformatf("t6 quiet busy c%0d", k), busy_o, 1'b0);
    end
    chk("t6 level end", level_o, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised UART transmitter. It combines a transmit FIFO, a programmable data length of 5..DATA_WIDTH bits, optional parity, 1 or 2 stop bits, back-to-back framing and break generation. It sits between the register/Wishbone slave logic, which pushes bytes, and the uart_tx pin. It generalises the single-byte transmit front-end by adding buffering, wider frames, status reporting and line-break support.

Parameters:
DATA_WIDTH, 9, maximum data bits per frame (5..16).
FIFO_DEPTH, 8, transmit FIFO entries; power of two, at least 2.

Ports:
clk_i  in  1  system clock.
rst_ni  in  1  asynchronous active-low reset.
cr_clk_div_i  in  16  clock cycles per bit; a value of 0 is treated as 1.
cr_dlen_i  in  5  data bits per frame; values below 5 clamp to 5, values above DATA_WIDTH clamp to DATA_WIDTH.
cr_p_i  in  2  parity: 00 none, 10 even, 01/11 odd.
cr_s_i  in  1  stop bits: 0 = one, 1 = two.
cr_brk_i  in  1  break request.
push_valid_i  in  1  write request.
push_data_i  in  DATA_WIDTH  frame data, sent LSB first.
push_ready_o  out  1  FIFO not full.
level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
busy_o  out  1  FSM not in IDLE.
done_o  out  1  one-cycle pulse per completed frame.
uart_tx_o  out  1  serial line, idle high.

Behaviour:
- Reset (asynchronous, rst_ni low):
  - uart_tx_o=1, push_ready_o=1, level_o=0, busy_o=0, done_o=0.
  - FIFO flushed; FSM goes to IDLE.
  - Reset mid-frame drops the line to high immediately; no partial frame resumes after reset.
- FIFO handshake:
  - A push occurs at a clock edge when push_valid_i && push_ready_o.
  - push_ready_o = !full; it depends only on the registered level, not on a same-cycle pop.
  - A push and a pop in the same cycle leave level_o unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push while full is ignored and stored data is not corrupted.
- Config latching: cr_clk_div_i, cr_dlen_i, cr_p_i and cr_s_i are captured on the pop at frame start. Changes mid-frame do not affect the current frame.
- Baud counter: loads clk_div-1 on entering each bit and decrements each cycle. Every bit, including parity and stop bits, lasts exactly clk_div cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: if cr_brk_i is set, go to BREAK (break has priority over pending data). Else if the FIFO is non-empty, pop and go to START.
  - START: line 0 for one bit, then DATA.
  - DATA: line = shift-register LSB, shift right each bit.
    - After dlen bits, go to PARITY if cr_p_i != 00, else STOP.
    - FIFO bits above dlen are ignored and excluded from parity.
  - PARITY: line = cr_p_i[0] XOR (XOR of the sent data bits), for one bit, then STOP.
  - STOP: line 1 for 1 or 2 bits. At the end of the last stop bit:
    - if !cr_brk_i and the FIFO is non-empty, pop and enter START directly (no idle gap);
    - otherwise go to IDLE.
  - BREAK: line 0 while cr_brk_i is high, for a minimum of one full bit period. On deassertion, go to STOP with one stop bit, then follow the normal STOP exit.
- Break requested mid-frame takes effect only after the current frame's stop bits.
- done_o: registered. It pulses high for one cycle, in the cycle after the last stop-bit cycle of a data frame. It does not pulse for the STOP that follows a break.
- uart_tx_o: decoded from registered state. The first start-bit cycle is the cycle after the pop edge. With an empty, idle engine, a push at edge E0 gives a pop at E1 and uart_tx_o=0 from E1.
- Frame length in cycles = clk_div × (1 + dlen + parity_en + stop_bits).

Test Plan:
- clk_div=4, dlen=8, no parity, 1 stop, push 0xA5 -> line low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4; frame 40 cycles; one done_o pulse; level returns to 0.
- clk_div=2, dlen=9, even parity, 2 stop, push 0x1A5 -> 9 data bits LSB first, parity bit 1, 2 stop bits; 26 cycles total.
- Push 3 words back-to-back, clk_div=1, 8N1 -> 30 consecutive cycles with no idle bit between frames; 3 done_o pulses, spaced 10 cycles apart.
- FIFO_DEPTH=4, engine stalled by break, push 5 words -> push_ready_o low after 4 pushes, level_o=4, 5th word dropped; all 4 stored words sent in order after break release.
- Assert cr_brk_i during frame 1 with a word pending -> frame 1 completes; line low for the full break duration (at least one bit); one stop bit; then the pending frame is sent; no done_o pulse for the break.
- Assert rst_ni low mid-DATA with 2 words queued -> uart_tx_o=1 in the same cycle, level_o=0; after release, nothing is transmitted.
